psi_bitonic: RTL and testbench

Pipelined N-party private-set-intersection core for the MPC circuit library. It takes N sorted K-element sets of W-bit values and returns their common elements as one sorted K-element set. A binary tree of log2(N) levels does the work. Each level bitonic-merges pairs of sets and keeps only the values present in both. It sits behind the party-input packer and feeds the garbled-circuit output stage.

---
 rtl/psi_bitonic_pkg.sv | 20 ++
 rtl/psi_bitonic_if.sv | 14 +
 rtl/psi_merge_dup.sv | 59 +++++
 rtl/psi_bitonic.sv | 67 ++++++
 tb/tb_psi_bitonic.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/psi_bitonic_pkg.sv
// Shared constants and helpers for the bitonic PSI tree.
// EMPTY marks an unused slot in a set; real elements are nonzero.
package psi_pkg;

  localparam int unsigned EMPTY = 0;

  // Ceiling log2, used to size merge stages and tree levels.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Depth of node k in a heap-indexed binary tree (root is node 0).
  function automatic int node_depth(input int k);
    return log2(k + 2) - 1;
  endfunction

endpackage

// File: rtl/psi_bitonic_if.sv
// Job input / result output bundle of the PSI core.
interface psi_bitonic_if #(
  parameter int W = 4,
  parameter int K = 4,
  parameter int N = 8
);
  logic               in_valid;
  logic [W*K*N-1:0]   p_input;
  logic               out_valid;
  logic [W*K-1:0]     o;

  modport master (output in_valid, p_input, input out_valid, o);
  modport slave  (input in_valid, p_input, output out_valid, o);
endinterface

// File: rtl/psi_merge_dup.sv
// Combinational bitonic merge of two sorted K-sets followed by
// compaction of duplicated (common) nonzero values into a K-set.
module psi_merge_dup
  import psi_pkg::*;
#(
  parameter int W = 4,
  parameter int K = 4
) (
  input  logic [W*K-1:0] a,
  input  logic [W*K-1:0] b,
  output logic [W*K-1:0] y
);

  localparam int STAGES = log2(2 * K);

  always_comb begin
    logic [W-1:0] x [2*K];
    logic [W-1:0] t;
    int d;
    int lo;
    int hi;
    int pos;

    t   = '0;
    d   = 0;
    lo  = 0;
    hi  = 0;
    pos = K - 1;
    y   = '0;

    // A ascending followed by B reversed forms one bitonic sequence.
    for (int i = 0; i < K; i++) begin
      x[i]     = a[(K-i)*W-1 -: W];
      x[K + i] = b[(i+1)*W-1 -: W];
    end

    for (int s = 0; s < STAGES; s++) begin
      d = K >> s;
      for (int i = 0; i < K; i++) begin
        lo = ((i / d) * 2 * d) + (i % d);
        hi = lo + d;
        if (x[lo] > x[hi]) begin
          t     = x[lo];
          x[lo] = x[hi];
          x[hi] = t;
        end
      end
    end

    // Scan from the top so the largest match lands in element K-1.
    for (int i = 2*K - 2; i >= 0; i--) begin
      if ((x[i] == x[i+1]) && (x[i] != W'(EMPTY)) && (pos >= 0)) begin
        y[(K-pos)*W-1 -: W] = x[i];
        pos = pos - 1;
      end
    end
  end

endmodule

// File: rtl/psi_bitonic.sv
// N-party set intersection: heap-indexed tree of registered merge
// nodes. Leaves N-1..2N-2 hold party inputs, node 0 is the final level.
module psi_bitonic
  import psi_pkg::*;
#(
  parameter int W = 4,
  parameter int K = 4,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  psi_bitonic_if.slave   bus
);

  localparam int LEVELS = log2(N);
  localparam int SW     = W * K;
  localparam int NODES  = 2 * N - 1;

  // valid_reg[d] qualifies the data registered at tree depth d.
  logic [LEVELS:0] valid_reg;
  logic [SW-1:0]   node_reg [NODES];
  logic [SW-1:0]   merged   [N-1];
  logic [SW-1:0]   party    [N];
  logic [N-2:0]    load;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_party
      assign party[gi] = bus.p_input[(gi+1)*SW-1 -: SW];
    end

    for (gi = 0; gi < N - 1; gi++) begin : g_node
      psi_merge_dup #(.W(W), .K(K)) u_merge (
        .a (node_reg[2*gi + 1]),
        .b (node_reg[2*gi + 2]),
        .y (merged[gi])
      );
      assign load[gi] = valid_reg[node_depth(gi) + 1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      for (int k = 0; k < NODES; k++) node_reg[k] <= '0;
    end else begin
      valid_reg <= {bus.in_valid, valid_reg[LEVELS:1]};
      for (int i = 0; i < N; i++) begin
        if (bus.in_valid) node_reg[N - 1 + i] <= party[i];
      end
      for (int k = 0; k < N - 1; k++) begin
        if (load[k]) node_reg[k] <= merged[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.o         <= '0;
    end else begin
      bus.out_valid <= valid_reg[0];
      if (valid_reg[0]) bus.o <= node_reg[0];
    end
  end

endmodule

// File: tb/tb_psi_bitonic.sv
// Directed bench for psi_bitonic with W=4, K=4, N=8.
module tb_psi_bitonic;

  localparam int W = 4;
  localparam int K = 4;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  psi_bitonic_if #(.W(W), .K(K), .N(N)) bus ();

  psi_bitonic #(.W(W), .K(K), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Eight parties, party 0 in the least significant slice.
  function automatic logic [127:0] pack(input logic [15:0] p [N]);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[(i+1)*16-1 -: 16] = p[i];
    return v;
  endfunction

  function automatic logic [127:0] all_same(input logic [15:0] s);
    logic [15:0] p [N];
    for (int i = 0; i < N; i++) p[i] = s;
    return pack(p);
  endfunction

  // Issue one job on the next edge, then check latency, result and pulse width.
  task automatic run_job(input string tag, input logic [127:0] pin, input logic [15:0] exp);
    int lat;
    bus.in_valid = 1'b1;
    bus.p_input  = pin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_o"}, {16'h0, bus.o}, {16'h0, exp});
    $display("job %s: o=%h latency=%0d", tag, bus.o, lat);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, {31'h0, bus.out_valid}, 0);
  endtask

  logic [15:0]  parts [N];
  logic [127:0] job_a;
  logic [127:0] job_b;
  logic [127:0] job_c;
  int           seen;

  initial begin
    bus.in_valid = 1'b0;
    bus.p_input  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, bus.out_valid}, 0);
    check("reset_o", {16'h0, bus.o}, 0);
    rst = 1'b0;

    // Job right after reset release; parties 7..0 from the worked example.
    parts[7] = 16'h1234; parts[6] = 16'h2456; parts[5] = 16'h1267; parts[4] = 16'h2567;
    parts[3] = 16'h1235; parts[2] = 16'h2567; parts[1] = 16'h3467; parts[0] = 16'h3567;
    run_job("example", pack(parts), 16'h0000);

    run_job("all_1234", all_same(16'h1234), 16'h1234);

    for (int i = 0; i < N; i++) parts[i] = {4'h0, 4'h5, 4'(8 + i % 4), 4'(12 + i / 4)};
    run_job("common_5", pack(parts), 16'h0005);

    for (int i = 0; i < N; i++) parts[i] = 16'h1234;
    parts[3] = 16'h0000;
    run_job("empty_party", pack(parts), 16'h0000);

    for (int i = 0; i < N; i++) parts[i] = 16'h1234;
    parts[5] = 16'h0139;
    run_job("partial", pack(parts), 16'h0013);

    run_job("max_vals", all_same(16'hCDEF), 16'hCDEF);
    run_job("single_f", all_same(16'h000F), 16'h000F);

    // Three back-to-back jobs.
    job_a = all_same(16'h2468);
    job_b = pack(parts);
    job_c = all_same(16'h1234);
    bus.in_valid = 1'b1;
    bus.p_input  = job_a;
    @(posedge clk); #1;
    bus.p_input  = job_b;
    @(posedge clk); #1;
    bus.p_input  = job_c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_pre", {31'h0, bus.out_valid}, 0);
    @(posedge clk); #1;
    check("b2b_v0", {31'h0, bus.out_valid}, 1);
    check("b2b_o0", {16'h0, bus.o}, 32'h2468);
    $display("job b2b_0: o=%h", bus.o);
    @(posedge clk); #1;
    check("b2b_v1", {31'h0, bus.out_valid}, 1);
    check("b2b_o1", {16'h0, bus.o}, 32'h0013);
    $display("job b2b_1: o=%h", bus.o);
    @(posedge clk); #1;
    check("b2b_v2", {31'h0, bus.out_valid}, 1);
    check("b2b_o2", {16'h0, bus.o}, 32'h1234);
    $display("job b2b_2: o=%h", bus.o);
    @(posedge clk); #1;
    check("b2b_post", {31'h0, bus.out_valid}, 0);

    // Reset two cycles into a job: the job must vanish and o must clear.
    bus.in_valid = 1'b1;
    bus.p_input  = all_same(16'h5678);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'h0, bus.out_valid}, 0);
    check("rst_o", {16'h0, bus.o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("rst_drop", seen, 0);
    $display("job reset_drop: out_valid pulses=%0d", seen);

    run_job("after_rst", all_same(16'h5678), 16'h5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
